// File: rtl/mmio_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter:
// MMIO addresses, status word layout and TX state encoding.
package mmio_pkg;

  localparam logic [11:0] TX_ADDR   = 12'hFFC;
  localparam logic [11:0] STAT_ADDR = 12'hFFD;

  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_BUSY    = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 4;
  localparam int unsigned STAT_CNT_W   = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  // Assemble the processor-visible status word; unused bits read as zero.
  function automatic logic [31:0] pack_status(input logic full, input logic empty,
                                              input logic busy, input logic ovf,
                                              input logic [STAT_CNT_W-1:0] cnt);
    logic [31:0] s;
    s = '0;
    s[STAT_FULL]  = full;
    s[STAT_EMPTY] = empty;
    s[STAT_BUSY]  = busy;
    s[STAT_OVF]   = ovf;
    s[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO with extra-MSB pointers; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [7:0]               i_din,
  output logic [7:0]               o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  logic        w_push;
  logic        w_pop;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_count = r_wr - r_rd;
  assign o_dout  = r_mem[r_rd[AW-1:0]];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_pop)  r_rd <= r_rd + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter on the data-memory bus: decodes TX/status addresses,
// queues bytes in a FIFO and shifts them out 8N1; other accesses go to RAM.
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter logic [11:0] TX_ADDR      = mmio_pkg::TX_ADDR,
  parameter logic [11:0] STAT_ADDR    = mmio_pkg::STAT_ADDR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wren,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  output logic [31:0] q_dmem,
  output logic        ram_wEn,
  input  logic [31:0] ram_dataOut,
  output logic        uart_tx
);

  import mmio_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  tx_state_e   r_state;
  logic [BW-1:0] r_baud;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        r_ovf;
  logic        r_sel;
  logic [31:0] r_status;

  logic          w_hit_tx;
  logic          w_hit_stat;
  logic          w_push;
  logic          w_pop;
  logic          w_rd_stat;
  logic          w_ovf_set;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [7:0]    w_dout;
  logic [31:0]   w_status;
  logic          w_baud_end;
  logic          w_unused;

  assign w_hit_tx   = (address_dmem[11:0] == TX_ADDR);
  assign w_hit_stat = (address_dmem[11:0] == STAT_ADDR);
  assign ram_wEn    = wren & ~w_hit_tx & ~w_hit_stat;
  assign w_push     = wren & w_hit_tx;
  assign w_rd_stat  = w_hit_stat & ~wren;
  assign w_pop      = (r_state == S_IDLE) & ~w_empty;
  assign w_ovf_set  = w_push & w_full & ~w_pop;
  assign w_baud_end = (r_baud == BW'(CLKS_PER_BIT - 1));
  assign w_unused   = ^{address_dmem[31:12], data[31:8]};

  assign w_status = pack_status(w_full, w_empty, r_state != S_IDLE, r_ovf,
                                STAT_CNT_W'(w_count));

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (data[7:0]),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Bus side: sticky overflow (set beats clear) and one-cycle status read path.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ovf    <= 1'b0;
      r_sel    <= 1'b0;
      r_status <= '0;
    end else begin
      r_ovf <= w_ovf_set | (r_ovf & ~w_rd_stat);
      r_sel <= w_hit_stat;
      if (w_hit_stat) r_status <= w_status;
    end
  end

  assign q_dmem = r_sel ? r_status : ram_dataOut;

  // TX state machine; the line register follows the state one cycle later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (!w_empty) begin
            r_shift <= w_dout;
            r_baud  <= '0;
            r_state <= S_START;
          end
        end
        S_START: begin
          r_tx <= 1'b0;
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= S_DATA;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_DATA: begin
          r_tx <= r_shift[0];
          if (w_baud_end) begin
            r_baud  <= '0;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit == 3'd7) r_state <= S_STOP;
            else               r_bit   <= r_bit + 3'd1;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_STOP: begin
          r_tx <= 1'b1;
          if (w_baud_end) begin
            r_baud  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign uart_tx = r_tx;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: bus-side stimulus with a RAM model,
// and a line monitor that decodes 8N1 frames against a queue of expected bytes.
module tb_mmio_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int          FRAME = 10 * CPB + 1;
  localparam logic [11:0] A_TX   = 12'hFFC;
  localparam logic [11:0] A_STAT = 12'hFFD;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        wren  = 1'b0;
  logic [31:0] address_dmem = '0;
  logic [31:0] data = '0;
  logic [31:0] q_dmem;
  logic        ram_wEn;
  logic [31:0] ram_dataOut;
  logic        uart_tx;

  always #5 clock = ~clock;

  mmio_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .wren         (wren),
    .address_dmem (address_dmem),
    .data         (data),
    .q_dmem       (q_dmem),
    .ram_wEn      (ram_wEn),
    .ram_dataOut  (ram_dataOut),
    .uart_tx      (uart_tx)
  );

  // Synchronous RAM behind the MMIO block.
  logic [31:0] ram [0:4095];
  always @(posedge clock) begin
    if (ram_wEn) ram[address_dmem[11:0]] <= data;
    ram_dataOut <= ram[address_dmem[11:0]];
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int store_cyc = 0;
  int n_frames = 0;
  logic [7:0] exp_q[$];
  int starts[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Line monitor: sample each bit mid-way, compare against the scoreboard.
  logic       m_act = 1'b0;
  int         m_ph  = 0;
  int         m_k   = 0;
  logic [7:0] m_byte = '0;
  always @(negedge clock) begin
    if (!reset) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (uart_tx === 1'b0) begin
        m_act = 1'b1;
        m_ph  = 0;
        starts.push_back(cyc);
      end
    end else begin
      m_ph++;
      if (m_ph >= CPB/2 && ((m_ph - CPB/2) % CPB) == 0) begin
        m_k = (m_ph - CPB/2) / CPB;
        if (m_k == 0) begin
          chk("start_bit", 32'(uart_tx), 32'd0);
        end else if (m_k <= 8) begin
          m_byte[m_k-1] = uart_tx;
        end else begin
          chk("stop_bit", 32'(uart_tx), 32'd1);
          n_frames++;
          chk("frame_queued", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) chk("rx_byte", 32'(m_byte), 32'(exp_q.pop_front()));
          m_act = 1'b0;
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic store(input logic [11:0] a, input logic [31:0] d);
    logic exp_wen;
    @(negedge clock);
    wren = 1'b1;
    address_dmem = {20'h0, a};
    data = d;
    exp_wen = (a != A_TX) && (a != A_STAT);
    #1 chk("ram_wEn", 32'(ram_wEn), 32'(exp_wen));
    @(posedge clock);
    #1 store_cyc = cyc;
  endtask

  task automatic bus_idle();
    @(negedge clock);
    wren = 1'b0;
    address_dmem = '0;
    data = '0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] q);
    @(negedge clock);
    wren = 1'b0;
    address_dmem = {20'h0, a};
    @(negedge clock);
    q = q_dmem;
  endtask

  logic [31:0] q;
  int s0;
  int base;

  initial begin
    // Reset and idle
    wait_cyc(3);
    chk("reset_tx", 32'(uart_tx), 32'd1);
    reset = 1'b1;
    wait_cyc(2);
    chk("idle_tx", 32'(uart_tx), 32'd1);
    rd(A_STAT, q);
    chk("stat_reset", q, 32'h0000_0002);
    store(12'h010, 32'h1234_5678);
    bus_idle();
    store(A_STAT, 32'h0000_00FF);
    bus_idle();
    rd(A_STAT, q);
    chk("stat_after_wr", q, 32'h0000_0002);
    bus_idle();

    // Single byte with start-bit latency
    starts.delete();
    exp_q.push_back(8'hA5);
    store(A_TX, 32'h0000_00A5);
    s0 = store_cyc;
    bus_idle();
    wait_cyc(FRAME + 5);
    chk("single_frames", 32'(starts.size()), 32'd1);
    if (starts.size() > 0) chk("start_latency", 32'(starts[0] - s0), 32'd2);

    // Pass-through and busy status
    store(12'h020, 32'hDEAD_BEEF);
    bus_idle();
    rd(12'h020, q);
    chk("ram_readback", q, 32'hDEAD_BEEF);
    exp_q.push_back(8'h3C);
    store(A_TX, 32'h0000_003C);
    bus_idle();
    wait_cyc(5);
    rd(A_STAT, q);
    chk("stat_busy", q, 32'h0000_0006);
    bus_idle();
    wait_cyc(FRAME + 5);

    // Burst: sixth store overflows
    starts.delete();
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_q.push_back(8'(8'h11 + i));
      store(A_TX, 32'(8'h11 + i));
    end
    rd(A_STAT, q);
    chk("stat_overflow", q, 32'h0000_004D);
    rd(A_STAT, q);
    chk("stat_ovf_clear", q, 32'h0000_0045);
    bus_idle();
    wait_cyc(5 * FRAME + 10);
    chk("burst_frames", 32'(starts.size()), 32'd5);
    for (int i = 1; i < 5; i++)
      if (i < starts.size()) chk("burst_gap", 32'(starts[i] - starts[i-1]), 32'(FRAME));
    chk("burst_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame during data bit 3 (0x52 has bit 3 low)
    exp_q.push_back(8'h52);
    store(A_TX, 32'h0000_0052);
    bus_idle();
    wait_cyc(19);
    chk("bit3_low", 32'(uart_tx), 32'd0);
    reset = 1'b0;
    #1 chk("reset_async_tx", 32'(uart_tx), 32'd1);
    exp_q.delete();
    wait_cyc(2);
    reset = 1'b1;
    base = starts.size();
    rd(A_STAT, q);
    chk("stat_after_reset", q, 32'h0000_0002);
    bus_idle();
    wait_cyc(2 * FRAME);
    chk("no_tx_after_reset", 32'(starts.size() - base), 32'd0);
    chk("line_idle_after_reset", 32'(uart_tx), 32'd1);

    // Pointer wrap: ten spaced bytes
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(8'(i * 37 + 3));
      store(A_TX, 32'(8'(i * 37 + 3)));
      bus_idle();
      wait_cyc(FRAME + 4);
      rd(A_STAT, q);
      chk("wrap_stat", q, 32'h0000_0002);
      bus_idle();
    end
    chk("rx_pending", 32'(exp_q.size()), 32'd0);
    chk("frames_total", 32'(n_frames), 32'd17);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
